stream_demux1xn: RTL and testbench

- Registered 1-to-N demultiplexer for valid/ready byte streams. It is the distribution counterpart of the team's 2:1 selector.
- Routes each packet from a single input stream to the output port chosen by sel. The destination is locked for the whole packet.
- Drops packets addressed to a non-existent port and counts them.
- Sits between a packet source and N consumer channels.

---
 rtl/stream_demux1xn_if.sv | 28 ++
 rtl/stream_demux1xn.sv | 132 +++++++++++++
 tb/tb_stream_demux1xn.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux1xn_if.sv
// Valid/ready bundle for the 1-to-N stream demultiplexer: one input stream
// plus N flattened output streams. The master side is the packet source and
// the consumers; the slave side is the demultiplexer itself.
interface stream_demux1xn_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SEL_W = 2
);
  logic [WIDTH-1:0]       s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;
  logic [SEL_W-1:0]       sel;
  logic [N_OUT*WIDTH-1:0] m_data;
  logic [N_OUT-1:0]       m_valid;
  logic [N_OUT-1:0]       m_last;
  logic [N_OUT-1:0]       m_ready;

  modport master (
    output s_data, s_valid, s_last, sel, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, s_last, sel, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/stream_demux1xn.sv
// Registered 1-to-N packet demultiplexer. The destination is taken from sel
// on a packet's first beat and held until its last beat. Packets addressed
// to a port that does not exist are swallowed and counted in drop_cnt.
module stream_demux1xn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_demux1xn_if.slave    bus,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             hv_q, hv_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic ready_dest;
  logic drain;
  logic accept;
  logic sel_ok;
  logic load;
  logic drop_done;

  // Ready of the port currently holding the beat; unselected ports are ignored.
  always_comb begin
    ready_dest = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (dest_q == SEL_W'(i)) ready_dest = bus.m_ready[i];
    end
  end

  assign drain       = hv_q && ready_dest;
  // Drop state swallows beats unconditionally; otherwise fill as the register drains.
  assign bus.s_ready = (state_q == StDrop) || !hv_q || ready_dest;
  assign accept      = bus.s_valid && bus.s_ready;
  assign sel_ok      = 32'(bus.sel) < N_OUT;

  // Packet FSM and holding-register next state.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_d     = last_q;
    hv_d       = hv_q;
    dest_d     = dest_q;
    drop_cnt_d = drop_cnt_q;
    load       = 1'b0;
    drop_done  = 1'b0;

    if (drain) hv_d = 1'b0;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (sel_ok) begin
            load   = 1'b1;
            dest_d = bus.sel;
            if (!bus.s_last) state_d = StPkt;
          end else if (bus.s_last) begin
            drop_done = 1'b1;
          end else begin
            state_d = StDrop;
          end
        end
        StPkt: begin
          load = 1'b1;
          if (bus.s_last) state_d = StIdle;
        end
        StDrop: begin
          if (bus.s_last) begin
            drop_done = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A load wins over a same-cycle drain: pass-through without a bubble.
    if (load) begin
      hv_d   = 1'b1;
      data_d = bus.s_data;
      last_d = bus.s_last;
    end

    if (drop_done && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // State and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      last_q     <= 1'b0;
      hv_q       <= 1'b0;
      dest_q     <= '0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_q     <= last_d;
      hv_q       <= hv_d;
      dest_q     <= dest_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Fan the holding register out to the selected port only.
  always_comb begin
    bus.m_valid = '0;
    bus.m_last  = '0;
    bus.m_data  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (hv_q && (dest_q == SEL_W'(i))) begin
        bus.m_valid[i]               = 1'b1;
        bus.m_last[i]                = last_q;
        bus.m_data[i*WIDTH +: WIDTH] = data_q;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux1xn.sv
// Bench for stream_demux1xn: a packet-level scoreboard predicts what every
// port must show each cycle, and directed sequences pin key values by hand.
module tb_stream_demux1xn;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned SEL_W = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] drop_cnt;

  stream_demux1xn_if #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W)) bus ();

  stream_demux1xn #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
  } beat_t;

  // Scoreboard: beats accepted but not yet delivered, plus packet context.
  beat_t      exp_q[$];
  bit         in_pkt;
  bit         dropping;
  logic [1:0] cur_port;
  int         drop_exp;

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    in_pkt   = 1'b0;
    dropping = 1'b0;
    drop_exp = 0;
  endtask

  int    mon_qp;
  bit    mon_rdy;
  beat_t mon_b;

  // Per-cycle compare, sampled just before the rising edge.
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1) begin
      mon_qp = (exp_q.size() > 0) ? int'(exp_q[0].port) : -1;
      if (in_pkt && dropping) mon_rdy = 1'b1;
      else if (mon_qp < 0)    mon_rdy = 1'b1;
      else                    mon_rdy = bus.m_ready[mon_qp];
      chk("s_ready", 32'(bus.s_ready), 32'(mon_rdy));
      chk("busy", 32'(busy), 32'(in_pkt));
      chk("drop_cnt", 32'(drop_cnt), drop_exp);
      for (int i = 0; i < N_OUT; i++) begin
        if (mon_qp == i) begin
          chk("m_valid", 32'(bus.m_valid[i]), 32'd1);
          chk("m_data", 32'(bus.m_data[i*WIDTH +: WIDTH]), 32'(exp_q[0].data));
          chk("m_last", 32'(bus.m_last[i]), 32'(exp_q[0].last));
        end else begin
          chk("m_valid_idle", 32'(bus.m_valid[i]), 32'd0);
          chk("m_data_idle", 32'(bus.m_data[i*WIDTH +: WIDTH]), 32'd0);
          chk("m_last_idle", 32'(bus.m_last[i]), 32'd0);
        end
      end
      // Drain first, then fill: the register may do both on one edge.
      if (mon_qp >= 0 && bus.m_ready[mon_qp]) void'(exp_q.pop_front());
      if (bus.s_valid && bus.s_ready) begin
        mon_b.data = bus.s_data;
        mon_b.last = bus.s_last;
        if (!in_pkt) begin
          in_pkt = !bus.s_last;
          if (int'(bus.sel) < N_OUT) begin
            dropping   = 1'b0;
            cur_port   = bus.sel;
            mon_b.port = bus.sel;
            exp_q.push_back(mon_b);
          end else begin
            dropping = 1'b1;
            if (bus.s_last && drop_exp < 255) drop_exp++;
          end
        end else if (dropping) begin
          if (bus.s_last) begin
            in_pkt = 1'b0;
            if (drop_exp < 255) drop_exp++;
          end
        end else begin
          mon_b.port = cur_port;
          exp_q.push_back(mon_b);
          if (bus.s_last) in_pkt = 1'b0;
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s);
    int n;
    n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.sel     = s;
    #3;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      #3;
      n++;
      stalls++;
    end
    if (n >= 100) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: s_ready stayed %0b for %0d cycles", bus.s_ready, n);
    end
    @(posedge clk);
  endtask

  // Idle one cycle and stop at the sample point.
  task automatic sample();
    @(negedge clk);
    bus.s_valid = 1'b0;
    #3;
  endtask

  // Assert reset 2 time units after a rising edge, then settle 1 unit.
  task automatic async_reset();
    #2;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    model_clear();
    #1;
  endtask

  int stall0;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.sel     = '0;
    bus.m_ready = 3'b111;
    model_clear();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst0_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst0_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst0_busy", 32'(busy), 32'd0);
    chk("rst0_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-beat routing to each port.
    send(8'hA0, 1'b1, 2'd0);
    sample();
    chk("route0_valid", 32'(bus.m_valid), 32'h1);
    chk("route0_data", 32'(bus.m_data), 32'h0000A0);
    chk("route0_last", 32'(bus.m_last), 32'h1);
    send(8'hA1, 1'b1, 2'd1);
    sample();
    chk("route1_valid", 32'(bus.m_valid), 32'h2);
    chk("route1_data", 32'(bus.m_data), 32'h00A100);
    send(8'hA2, 1'b1, 2'd2);
    sample();
    chk("route2_valid", 32'(bus.m_valid), 32'h4);
    chk("route2_data", 32'(bus.m_data), 32'hA20000);
    chk("route2_last", 32'(bus.m_last), 32'h4);

    // Destination locked on the first beat despite sel changing.
    send(8'h11, 1'b0, 2'd1);
    sample();
    chk("lock_busy", 32'(busy), 32'd1);
    chk("lock_valid1", 32'(bus.m_valid), 32'h2);
    send(8'h22, 1'b0, 2'd2);
    send(8'h33, 1'b0, 2'd2);
    send(8'h44, 1'b1, 2'd2);
    sample();
    chk("lock_busy_end", 32'(busy), 32'd0);
    chk("lock_valid4", 32'(bus.m_valid), 32'h2);
    chk("lock_data4", 32'(bus.m_data), 32'h004400);

    // Backpressure on port 2, then release with a pass-through beat.
    @(negedge clk);
    bus.m_ready = 3'b011;
    send(8'h5A, 1'b1, 2'd2);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
      chk("bp_data2", 32'(bus.m_data[2*WIDTH +: WIDTH]), 32'h5A);
      chk("bp_valid", 32'(bus.m_valid), 32'h4);
    end
    @(negedge clk);
    bus.m_ready = 3'b111;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5B;
    bus.s_last  = 1'b1;
    bus.sel     = 2'd0;
    #3;
    chk("bp_release_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    sample();
    chk("bp_next_valid", 32'(bus.m_valid), 32'h1);
    chk("bp_next_data", 32'(bus.m_data), 32'h00005B);

    // Dropped packets and saturation of the drop counter.
    send(8'h01, 1'b0, 2'd3);
    send(8'h02, 1'b0, 2'd3);
    sample();
    chk("drop_mid_cnt", 32'(drop_cnt), 32'd0);
    chk("drop_mid_busy", 32'(busy), 32'd1);
    send(8'h03, 1'b1, 2'd3);
    sample();
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("drop_valid", 32'(bus.m_valid), 32'd0);
    for (int k = 0; k < 256; k++) send(8'(k), 1'b1, 2'd3);
    sample();
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Asynchronous reset mid-clock with a beat stuck in the register.
    @(negedge clk);
    bus.m_ready = 3'b000;
    send(8'h66, 1'b0, 2'd1);
    sample();
    chk("pre_rst_valid", 32'(bus.m_valid), 32'h2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    async_reset();
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    @(negedge clk);
    bus.m_ready = 3'b111;
    rst_n       = 1'b1;

    // Back-to-back single-beat packets alternating ports 0 and 2.
    stall0 = stalls;
    for (int k = 0; k < 8; k++) send(8'h60 + 8'(k), 1'b1, (k % 2 == 0) ? 2'd0 : 2'd2);
    chk("b2b_stalls", stalls - stall0, 32'd0);

    // Reset in the middle of a 3-beat packet, then route a fresh packet.
    send(8'h91, 1'b0, 2'd1);
    send(8'h92, 1'b0, 2'd1);
    async_reset();
    chk("rst2_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sample();
    chk("post_rst_valid", 32'(bus.m_valid), 32'd0);
    send(8'h77, 1'b1, 2'd1);
    sample();
    chk("post_rst_route", 32'(bus.m_valid), 32'h2);
    chk("post_rst_data", 32'(bus.m_data), 32'h007700);
    repeat (3) sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
